// File: rtl/i2c_bus_monitor_pkg.sv
// Shared definitions for the I2C bus monitor: bus state encodings and a counter-width helper.
package i2c_bus_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        BUF  = 2'd2
    } bus_state_e;

    // Width needed to hold 0..max_val, never less than one bit.
    function automatic int clog2_min1(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line glitch filter: the filtered level follows the raw line only after a persistent mismatch.
module i2c_glitch_filter
    import i2c_bus_monitor_pkg::*;
#(
    parameter int TR_CYC = 2,
    parameter int TF_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic lin,
    output logic lf,
    output logic hilo,
    output logic lohi
);

    localparam int MAX_CYC = (TR_CYC > TF_CYC) ? TR_CYC : TF_CYC;
    localparam int CW = clog2_min1(MAX_CYC);
    localparam logic [CW-1:0] TR_LIM = CW'(TR_CYC);
    localparam logic [CW-1:0] TF_LIM = CW'(TF_CYC);

    logic [CW-1:0] cnt;
    logic [CW-1:0] lim;

    // A filtered high is heading low, so the falling threshold applies.
    assign lim = lf ? TF_LIM : TR_LIM;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lf   <= 1'b1;
            cnt  <= '0;
            hilo <= 1'b0;
            lohi <= 1'b0;
        end else begin
            hilo <= 1'b0;
            lohi <= 1'b0;
            if (lin == lf) begin
                cnt <= '0;
            end else if (cnt >= lim) begin
                lf   <= lin;
                cnt  <= '0;
                hilo <= lf;
                lohi <= ~lf;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: filtered lines, edge pulses, START/repeated START/STOP, bus-busy with tBUF.
// Optional SCL stuck-low timeout is built only when I2C_BUSMON_TIMEOUT_EN is defined.
module i2c_bus_monitor
    import i2c_bus_monitor_pkg::*;
#(
    parameter int TR_CYC     = 2,
    parameter int TF_CYC     = 2,
    parameter int TBUF_CYC   = 50
`ifdef I2C_BUSMON_TIMEOUT_EN
    ,
    parameter int SCL_TO_CYC = 1000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic sda,
    input  logic scl,
    output logic sda_f,
    output logic scl_f,
    output logic sda_hilo,
    output logic sda_lohi,
    output logic scl_hilo,
    output logic scl_lohi,
    output logic sta,
    output logic rsta,
    output logic sto,
    output logic bby,
    output logic tout
);

    localparam int BW = clog2_min1(TBUF_CYC);
    localparam logic [BW-1:0] BUF_LOAD = BW'(TBUF_CYC);

    bus_state_e    state, state_n;
    logic [BW-1:0] buf_cnt, buf_n;
    logic          scl_prev;

    i2c_glitch_filter #(.TR_CYC(TR_CYC), .TF_CYC(TF_CYC)) u_sda_filter (
        .clk  (clk),
        .rst  (rst),
        .lin  (sda),
        .lf   (sda_f),
        .hilo (sda_hilo),
        .lohi (sda_lohi)
    );

    i2c_glitch_filter #(.TR_CYC(TR_CYC), .TF_CYC(TF_CYC)) u_scl_filter (
        .clk  (clk),
        .rst  (rst),
        .lin  (scl),
        .lf   (scl_f),
        .hilo (scl_hilo),
        .lohi (scl_lohi)
    );

    // scl_prev is SCL as it was before the edge that raised the SDA pulse, so a
    // simultaneous SCL+SDA fall still counts as START.
    assign sta  = sda_hilo & scl_prev;
    assign sto  = sda_lohi & scl_prev;
    assign rsta = sta & (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buf_cnt  <= '0;
            bby      <= 1'b0;
            scl_prev <= 1'b1;
        end else begin
            state    <= state_n;
            buf_cnt  <= buf_n;
            bby      <= (state_n != IDLE);
            scl_prev <= scl_f;
        end
    end

    // BUF counts down the bus-free time; a zero tBUF skips BUF entirely.
    always_comb begin
        state_n = state;
        buf_n   = buf_cnt;
        case (state)
            IDLE: begin
                if (sta) state_n = BUSY;
            end
            BUSY: begin
                if (sto) begin
                    state_n = (TBUF_CYC == 0) ? IDLE : BUF;
                    buf_n   = BUF_LOAD;
                end
            end
            BUF: begin
                if (sta) begin
                    state_n = BUSY;
                end else if (sto) begin
                    buf_n = BUF_LOAD;
                end else if (buf_cnt <= BW'(1)) begin
                    state_n = IDLE;
                end else begin
                    buf_n = buf_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef I2C_BUSMON_TIMEOUT_EN
    localparam int TW = clog2_min1(SCL_TO_CYC);
    localparam logic [TW-1:0] TO_MAX = TW'(SCL_TO_CYC);

    logic [TW-1:0] to_cnt;

    // Timeout only watches a busy bus; tout stays set until SCL rises or BUSY is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            tout   <= 1'b0;
        end else begin
            if (state != BUSY || scl_f) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (scl_lohi || state != BUSY) begin
                tout <= 1'b0;
            end else if (to_cnt == TO_MAX) begin
                tout <= 1'b1;
            end
        end
    end
`else
    assign tout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor with default parameters (TR=TF=2, TBUF=50).
module tb_i2c_bus_monitor;

    logic clk, rst, sda, scl;
    logic sda_f, scl_f, sda_hilo, sda_lohi, scl_hilo, scl_lohi;
    logic sta, rsta, sto, bby, tout;
    int   total  = 0;
    int   passes = 0;
    logic any_pulse;
    logic tout_exp;

    i2c_bus_monitor dut (
        .clk      (clk),
        .rst      (rst),
        .sda      (sda),
        .scl      (scl),
        .sda_f    (sda_f),
        .scl_f    (scl_f),
        .sda_hilo (sda_hilo),
        .sda_lohi (sda_lohi),
        .scl_hilo (scl_hilo),
        .scl_lohi (scl_lohi),
        .sta      (sta),
        .rsta     (rsta),
        .sto      (sto),
        .bby      (bby),
        .tout     (tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign any_pulse = sta | sto | rsta | sda_hilo | sda_lohi | scl_hilo | scl_lohi;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1;
        sda = 1'b1;
        scl = 1'b1;
        #12;
        check_output("reset_sda_f", sda_f, 1'b1);
        check_output("reset_scl_f", scl_f, 1'b1);
        check_output("reset_bby", bby, 1'b0);
        check_output("reset_pulses", any_pulse, 1'b0);
        check_output("reset_tout", tout, 1'b0);
        step();
        rst = 1'b0;
        step();

        $display("[TB] glitch rejection");
        sda = 1'b0;
        step();
        check_output("glitch_hilo_1", sda_hilo, 1'b0);
        step();
        check_output("glitch_hilo_2", sda_hilo, 1'b0);
        sda = 1'b1;
        step();
        check_output("glitch_hilo_3", sda_hilo, 1'b0);
        check_output("glitch_sda_f", sda_f, 1'b1);
        step(3);
        check_output("glitch_quiet", any_pulse, 1'b0);

        $display("[TB] START from idle");
        sda = 1'b0;
        step(2);
        check_output("start_hilo_early", sda_hilo, 1'b0);
        step();
        check_output("start_hilo", sda_hilo, 1'b1);
        check_output("start_sda_f", sda_f, 1'b0);
        check_output("start_sta", sta, 1'b1);
        check_output("start_rsta", rsta, 1'b0);
        step();
        check_output("start_sta_clear", sta, 1'b0);
        check_output("start_bby", bby, 1'b1);

        $display("[TB] SCL toggle and data change");
        scl = 1'b0;
        step(3);
        check_output("scl_hilo", scl_hilo, 1'b1);
        check_output("scl_f_low", scl_f, 1'b0);
        check_output("scl_fall_no_sta", sta, 1'b0);
        step();
        sda = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("data_rise_no_sto", sto, 1'b0);
        end
        check_output("data_sda_f", sda_f, 1'b1);
        scl = 1'b1;
        step(4);
        check_output("scl_f_high", scl_f, 1'b1);

        $display("[TB] repeated START");
        sda = 1'b0;
        step(3);
        check_output("rstart_sta", sta, 1'b1);
        check_output("rstart_rsta", rsta, 1'b1);
        check_output("rstart_bby", bby, 1'b1);
        step();
        check_output("rstart_rsta_clear", rsta, 1'b0);
        check_output("rstart_bby_hold", bby, 1'b1);

        $display("[TB] STOP and bus-free time");
        sda = 1'b1;
        step(3);
        check_output("stop_sto", sto, 1'b1);
        check_output("stop_no_sta", sta, 1'b0);
        for (int i = 1; i <= 50; i++) begin
            step();
            check_output("tbuf_bby_high", bby, 1'b1);
        end
        step();
        check_output("tbuf_bby_drop", bby, 1'b0);

        $display("[TB] START inside bus-free time");
        sda = 1'b0;
        step(3);
        check_output("buf_start_sta", sta, 1'b1);
        check_output("buf_start_rsta", rsta, 1'b0);
        step();
        sda = 1'b1;
        step(3);
        check_output("buf_stop_sto", sto, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            step();
            check_output("buf_bby_pre", bby, 1'b1);
        end
        sda = 1'b0;
        step(3);
        check_output("buf_sta_c20", sta, 1'b1);
        check_output("buf_rsta_c20", rsta, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            check_output("buf_bby_held", bby, 1'b1);
        end
        sda = 1'b1;
        step(3);
        check_output("close_sto", sto, 1'b1);
        step(51);
        check_output("close_idle", bby, 1'b0);

        $display("[TB] simultaneous SCL and SDA fall");
        sda = 1'b0;
        scl = 1'b0;
        step(3);
        check_output("simul_sta", sta, 1'b1);
        check_output("simul_rsta", rsta, 1'b0);
        check_output("simul_sda_hilo", sda_hilo, 1'b1);
        check_output("simul_scl_hilo", scl_hilo, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("simul_sta_once", sta, 1'b0);
        end
        check_output("simul_bby", bby, 1'b1);
        sda = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("scl_low_no_sto", sto, 1'b0);
        end
        check_output("scl_low_sda_f", sda_f, 1'b1);
        check_output("scl_low_bby", bby, 1'b1);

        $display("[TB] reset while busy");
        sda = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("pre_reset_no_sta", sta, 1'b0);
        end
        check_output("pre_reset_sda_f", sda_f, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_bby", bby, 1'b0);
        check_output("async_rst_sda_f", sda_f, 1'b1);
        check_output("async_rst_scl_f", scl_f, 1'b1);
        sda = 1'b1;
        scl = 1'b1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("release_no_pulse", any_pulse, 1'b0);
            check_output("release_bby", bby, 1'b0);
        end

        $display("[TB] SCL held low while busy");
`ifdef I2C_BUSMON_TIMEOUT_EN
        tout_exp = 1'b1;
`else
        tout_exp = 1'b0;
`endif
        sda = 1'b0;
        step(4);
        check_output("to_bby", bby, 1'b1);
        scl = 1'b0;
        step(1010);
        check_output("to_tout", tout, tout_exp);
        check_output("to_bby_hold", bby, 1'b1);
        scl = 1'b1;
        step(5);
        check_output("to_tout_clear", tout, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
